// File: rtl/spi_master_controller_if.sv
// CPU-side register bus of the SPI master.
// The CPU drives the master modport, the controller takes the slave side.
interface spi_master_controller_if;
    logic [3:0] Address;
    logic       SPI_Enable_H;
    logic       WE_L;
    logic [7:0] DataIn;
    logic [7:0] DataOut;
    logic       IRQ_L;

    modport master (
        output Address, SPI_Enable_H, WE_L, DataIn,
        input  DataOut, IRQ_L
    );

    modport slave (
        input  Address, SPI_Enable_H, WE_L, DataIn,
        output DataOut, IRQ_L
    );
endinterface

// File: rtl/spi_master_controller.sv
// Register-mapped SPI mode-0 master: one byte per DATA write, MSB first.
// Software owns chip select; DONE can raise an active-low interrupt.
module spi_master_controller #(
    parameter int DIV_RESET = 3,
    parameter int DIV_W     = 4
) (
    input  logic Clk,
    input  logic Reset_L,
    spi_master_controller_if.slave bus,
    output logic SPI_SCLK,
    output logic SPI_MOSI,
    input  logic SPI_MISO,
    output logic SPI_CS_L
);
    localparam logic [1:0] R_CTRL = 2'd0;
    localparam logic [1:0] R_STAT = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;
    localparam logic [1:0] R_CS   = 2'd3;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, FIN} state_t;

    state_t           state_q;
    logic             sel_q;
    logic             en_q;
    logic             ie_q;
    logic             cs_q;
    logic             irq_l_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_act_q;
    logic [DIV_W-1:0] cnt_q;
    logic             sclk_q;
    logic             mosi_q;
    logic             busy_q;
    logic             done_q;
    logic             ovr_q;
    logic [7:0]       shreg_q;
    logic [7:0]       rxd_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       ctrl_rd;
    logic [1:0]       reg_sel;
    logic             wr_stb;
    logic             rd_stb;
    logic             unused_bits;

    // Odd offsets and the upper half of the window alias the base registers
    assign reg_sel     = bus.Address[2:1];
    assign wr_stb      = bus.SPI_Enable_H & ~sel_q & ~bus.WE_L;
    assign rd_stb      = bus.SPI_Enable_H & ~sel_q & bus.WE_L;
    assign unused_bits = ^{bus.Address[3], bus.Address[0], bus.DataIn[3]};

    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            sel_q   <= 1'b0;
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            div_q   <= DIV_W'(DIV_RESET);
            cs_q    <= 1'b0;
            irq_l_q <= 1'b1;
        end else begin
            sel_q   <= bus.SPI_Enable_H;
            irq_l_q <= ~(ie_q & done_q);
            if (wr_stb && reg_sel == R_CTRL) begin
                en_q  <= bus.DataIn[0];
                ie_q  <= bus.DataIn[1];
                div_q <= bus.DataIn[4 +: DIV_W];
            end
            if (wr_stb && reg_sel == R_CS)
                cs_q <= bus.DataIn[0];
        end
    end

    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q   <= IDLE;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            shreg_q   <= 8'h00;
            rxd_q     <= 8'h00;
            bit_cnt_q <= 3'd0;
            cnt_q     <= '0;
            div_act_q <= '0;
        end else begin
            if (wr_stb && reg_sel == R_STAT) begin
                if (bus.DataIn[1]) done_q <= 1'b0;
                if (bus.DataIn[2]) ovr_q  <= 1'b0;
            end
            if (rd_stb && reg_sel == R_DATA)
                done_q <= 1'b0;
            if (wr_stb && reg_sel == R_DATA && en_q && busy_q)
                ovr_q <= 1'b1;

            if (state_q != IDLE && !en_q) begin
                state_q <= IDLE;
                sclk_q  <= 1'b0;
                mosi_q  <= 1'b0;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (wr_stb && reg_sel == R_DATA && en_q) begin
                            shreg_q   <= bus.DataIn;
                            bit_cnt_q <= 3'd7;
                            busy_q    <= 1'b1;
                            mosi_q    <= bus.DataIn[7];
                            cnt_q     <= '0;
                            div_act_q <= div_q;
                            state_q   <= LOW;
                        end
                    end
                    LOW: begin
                        if (cnt_q == div_act_q) begin
                            cnt_q   <= '0;
                            sclk_q  <= 1'b1;
                            shreg_q <= {shreg_q[6:0], SPI_MISO};
                            state_q <= HIGH;
                        end else begin
                            cnt_q <= cnt_q + DIV_W'(1);
                        end
                    end
                    HIGH: begin
                        if (cnt_q == div_act_q) begin
                            cnt_q  <= '0;
                            sclk_q <= 1'b0;
                            if (bit_cnt_q == 3'd0) begin
                                state_q <= FIN;
                            end else begin
                                bit_cnt_q <= bit_cnt_q - 3'd1;
                                mosi_q    <= shreg_q[7];
                                state_q   <= LOW;
                            end
                        end else begin
                            cnt_q <= cnt_q + DIV_W'(1);
                        end
                    end
                    FIN: begin
                        // Placed after the W1C/read clears so a same-cycle set wins
                        rxd_q   <= shreg_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        mosi_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        ctrl_rd               = 8'h00;
        ctrl_rd[0]            = en_q;
        ctrl_rd[1]            = ie_q;
        ctrl_rd[4 +: DIV_W]   = div_q;
    end

    always_comb begin
        bus.DataOut = 8'h00;
        unique case (reg_sel)
            R_CTRL: bus.DataOut = ctrl_rd;
            R_STAT: bus.DataOut = {5'b0, ovr_q, done_q, busy_q};
            R_DATA: bus.DataOut = rxd_q;
            R_CS:   bus.DataOut = {7'b0, cs_q};
        endcase
    end

    assign bus.IRQ_L = irq_l_q;
    assign SPI_SCLK  = sclk_q;
    assign SPI_MOSI  = mosi_q;
    assign SPI_CS_L  = ~cs_q;
endmodule
